// File: rtl/fuzzy_pkg.sv
// Shared types and constants for the fuzzy coprocessor actuator stage.
// slew_toward() moves a duty value toward a target without overshooting it.
package fuzzy_pkg;

   typedef logic [7:0] duty_t;

   localparam duty_t PWM_TOP    = 8'd254;
   localparam int    PWM_PERIOD = 255;

   // The step and both bounds are computed in 9 bits, then clamped to 0..255 and to the target.
   function automatic duty_t slew_toward(duty_t cur, duty_t tgt, duty_t step);
      logic [8:0] up;
      logic [8:0] dn;
      up = {1'b0, cur} + {1'b0, step};
      dn = ({1'b0, cur} >= {1'b0, step}) ? ({1'b0, cur} - {1'b0, step}) : 9'd0;
      if (tgt > cur) begin
         return (up > {1'b0, tgt}) ? tgt : up[7:0];
      end else if (tgt < cur) begin
         return (dn < {1'b0, tgt}) ? tgt : dn[7:0];
      end
      return cur;
   endfunction

endpackage

// File: rtl/g_out_pwm_if.sv
// Controller-to-actuator bundle for g_out_pwm.
// The master side drives results and control; the slave side returns the PWM status.
interface g_out_pwm_if;
   import fuzzy_pkg::*;

   logic  en;
   logic  valid;
   duty_t G_out;
   logic  clr_trip;
   logic  pwm_out;
   duty_t duty_cur;
   logic  period_tick;
   logic  wdog_trip;

   modport master (
      output en, valid, G_out, clr_trip,
      input  pwm_out, duty_cur, period_tick, wdog_trip
   );

   modport slave (
      input  en, valid, G_out, clr_trip,
      output pwm_out, duty_cur, period_tick, wdog_trip
   );

endinterface

// File: rtl/pwm_prescaler.sv
// Divides clk into PWM count ticks: counts 0..PRESCALE-1 and ticks on the terminal count.
// Held at zero while disabled so each enabled stretch starts from a clean phase.
module pwm_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pcnt_q;
   logic [PW-1:0] pcnt_d;

   always_comb begin
      pcnt_d = pcnt_q;
      tick   = 1'b0;
      if (!en) begin
         pcnt_d = '0;
      end else if (pcnt_q == LAST) begin
         pcnt_d = '0;
         tick   = 1'b1;
      end else begin
         pcnt_d = pcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) pcnt_q <= '0;
      else     pcnt_q <= pcnt_d;
   end

endmodule

// File: rtl/g_out_pwm.sv
// Actuator stage: captures G_out results, drives a 255-tick PWM frame with boundary-aligned duty updates,
// and forces SAFE_DUTY when the period watchdog trips. Macro G_OUT_PWM_SLEW_EN enables slew limiting.
module g_out_pwm
   import fuzzy_pkg::*;
#(
   parameter int PRESCALE     = 1,
   parameter int WDOG_PERIODS = 16,
   parameter int SAFE_DUTY    = 0,
   parameter int SLEW_STEP    = 8
) (
   input  logic        clk,
   input  logic        rst,
   g_out_pwm_if.slave  bus
);

   localparam int WW = $clog2(WDOG_PERIODS + 1);
   localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_PERIODS - 1);
   localparam logic [WW-1:0] WDOG_MAX  = WW'(WDOG_PERIODS);

   generate
      if (PRESCALE < 1 || WDOG_PERIODS < 1 || SLEW_STEP < 1 || SAFE_DUTY < 0 || SAFE_DUTY > 255) begin : g_bad_cfg
         $error("g_out_pwm: parameter out of range");
      end
   endgenerate

   logic          tick;
   logic          boundary;
   logic          en_rise;
   logic          upd;
   logic          trip_set;
   duty_t         cnt_q, cnt_d;
   duty_t         duty_cur_q, duty_cur_d;
   duty_t         pend_q, pend_d;
   logic          pend_vld_q, pend_vld_d;
   logic [WW-1:0] wdog_q, wdog_d;
   logic          trip_q, trip_d;
   logic          en_q;
   logic          pwm_q, pwm_d;
   logic          ptick_q, ptick_d;
`ifdef G_OUT_PWM_SLEW_EN
   duty_t         target_q, target_d;
   duty_t         tgt;
`endif

   pwm_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (bus.en),
      .tick (tick)
   );

   always_comb begin
      cnt_d      = cnt_q;
      duty_cur_d = duty_cur_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      wdog_d     = wdog_q;
`ifdef G_OUT_PWM_SLEW_EN
      target_d   = target_q;
      tgt        = pend_vld_q ? pend_q : target_q;
`endif
      boundary   = tick && (cnt_q == PWM_TOP);
      // The first enabled cycle after en rises refreshes the duty but is not a real period end.
      en_rise    = bus.en && !en_q;
      upd        = boundary || en_rise;
      trip_set   = boundary && !bus.valid && (wdog_q == WDOG_LAST);

      if (!bus.en)   cnt_d = '0;
      else if (tick) cnt_d = boundary ? '0 : cnt_q + 8'd1;

      if (bus.valid) begin
         pend_d     = bus.G_out;
         pend_vld_d = 1'b1;
      end

      if (!bus.en || bus.valid || bus.clr_trip) wdog_d = '0;
      else if (boundary && wdog_q != WDOG_MAX)  wdog_d = wdog_q + 1'b1;

      if (trip_set)          trip_d = 1'b1;
      else if (bus.clr_trip) trip_d = 1'b0;
      else                   trip_d = trip_q;

      if (upd) begin
         if (trip_d) begin
            duty_cur_d = duty_t'(SAFE_DUTY);
         end else begin
`ifdef G_OUT_PWM_SLEW_EN
            target_d   = tgt;
            duty_cur_d = slew_toward(duty_cur_q, tgt, duty_t'(SLEW_STEP));
`else
            if (pend_vld_q) duty_cur_d = pend_q;
`endif
            // A result arriving on the update cycle itself stays pending for the next one.
            if (pend_vld_q) pend_vld_d = bus.valid;
         end
      end

      pwm_d   = bus.en && (cnt_q < duty_cur_q);
      ptick_d = boundary;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         duty_cur_q <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         wdog_q     <= '0;
         trip_q     <= 1'b0;
         en_q       <= 1'b0;
         pwm_q      <= 1'b0;
         ptick_q    <= 1'b0;
`ifdef G_OUT_PWM_SLEW_EN
         target_q   <= '0;
`endif
      end else begin
         cnt_q      <= cnt_d;
         duty_cur_q <= duty_cur_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         wdog_q     <= wdog_d;
         trip_q     <= trip_d;
         en_q       <= bus.en;
         pwm_q      <= pwm_d;
         ptick_q    <= ptick_d;
`ifdef G_OUT_PWM_SLEW_EN
         target_q   <= target_d;
`endif
      end
   end

   assign bus.pwm_out     = pwm_q;
   assign bus.duty_cur    = duty_cur_q;
   assign bus.period_tick = ptick_q;
   assign bus.wdog_trip   = trip_q;

endmodule
